pipe_perf_monitor: RTL

Synthesizable performance/event monitor for the pipelined CPU. It replaces the bench-side cycle/stall/flush counting with hardware counters.
- Counts run cycles plus NUM_EVT single-bit pipeline events (stall, flush, retire, ...).
- Stops automatically after a programmable cycle limit.
- Exposes counters through a registered select/readout port.
- Sits beside CPU top; events are tapped from hazard/control logic.

---
 rtl/pipe_perf_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle counter plus NUM_EVT saturating event counters with a registered readout.
// Optional PIPE_PERF_MONITOR_SNAPSHOT_EN adds snap_i and a shadow bank that feeds rd_data_o.
module pipe_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
`ifdef PIPE_PERF_MONITOR_SNAPSHOT_EN
  input  logic             snap_i,
  output logic [CNT_W-1:0] shd_o,
`endif
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef PIPE_PERF_MONITOR_SNAPSHOT_EN
  // Shadow captures the post-increment value so a snap includes the current cycle.
  logic [CNT_W-1:0] shd_q, shd_d;
  always_comb begin
    shd_d = shd_q;
    if (clr_i)       shd_d = '0;
    else if (snap_i) shd_d = cnt_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) shd_q <= '0;
    else       shd_q <= shd_d;
  end
  assign shd_o = shd_q;
`endif

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module pipe_perf_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int LIMIT_W = 16,
  parameter int SEL_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [LIMIT_W-1:0] cycle_limit_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
`ifdef PIPE_PERF_MONITOR_SNAPSHOT_EN
  input  logic               snap_i,
`endif
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               done_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic                        running_q, done_q;
  logic [CNT_W-1:0]            rd_data_q, rd_data_d;
  logic [NUM_EVT:0][CNT_W-1:0] cnt, rd_src;
  logic [NUM_EVT:0]            inc;
  logic                        counting, hit;

  assign counting = (state_q == S_RUN) && start_i;
  assign inc      = {evt_i & {NUM_EVT{counting}}, counting};
  assign hit      = counting && (cycle_limit_i != '0) &&
                    ((cnt[0] + CNT_W'(1)) == CNT_W'(cycle_limit_i));

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_ctr
    pipe_perf_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[k]),
`ifdef PIPE_PERF_MONITOR_SNAPSHOT_EN
      .snap_i(snap_i),
      .shd_o (rd_src[k]),
`endif
      .cnt_o (cnt[k]),
      .ovf_o (ovf_o[k])
    );
  end

`ifndef PIPE_PERF_MONITOR_SNAPSHOT_EN
  assign rd_src = cnt;
`endif

  always_comb begin
    state_d = state_q;
    if (clear_i) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_RUN;
        S_RUN:   if (!start_i) state_d = S_HOLD;
                 else if (hit) state_d = S_DONE;
        S_HOLD:  if (start_i) state_d = S_RUN;
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  // Readout reflects pre-edge values, so a clear still reports the old count once.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k <= NUM_EVT; k++)
      if (rd_sel_i == SEL_W'(k)) rd_data_d = rd_src[k];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
  assign running_o = running_q;
  assign done_o    = done_q;
endmodule
